// File: rtl/rr_wordmux_if.sv
// Handshake bundle between the word mux and its producers/consumer.
// The slave modport is the mux's own view of the bus.
interface rr_wordmux_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SELW     = 2
);
    logic [0:CHANNELS-1]       i_valid;
    logic [0:CHANNELS*WIDTH-1] i_data;
    logic [0:CHANNELS-1]       o_ready;
    logic                      i_rr;
    logic                      o_valid;
    logic [0:WIDTH-1]          o_data;
    logic [0:SELW-1]           o_sel;
    logic                      i_ready;

    modport slave (
        input  i_valid, i_data, i_rr, i_ready,
        output o_ready, o_valid, o_data, o_sel
    );

    modport master (
        output i_valid, i_data, i_rr, i_ready,
        input  o_ready, o_valid, o_data, o_sel
    );
endinterface

// File: rtl/rr_wordmux.sv
// N-channel word multiplexer with fixed-priority or round-robin arbitration
// feeding a single-entry output register with valid/ready handshake.
module rr_wordmux #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SELW     = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    rr_wordmux_if.slave   bus
);
    logic                r_valid;
    logic [0:WIDTH-1]    r_data;
    logic [SELW-1:0]     r_sel;
    logic [SELW-1:0]     r_ptr;

    logic                w_space;
    logic                w_found;
    logic                w_gnt_any;
    logic [SELW-1:0]     w_gnt_idx;
    logic [SELW:0]       w_cand;
    logic [SELW:0]       w_inc;
    logic [0:CHANNELS-1] w_ready;

    assign w_space = !r_valid || bus.i_ready;

    // Search starts at the pointer in round-robin mode, at channel 0 otherwise.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int off = 0; off < CHANNELS; off++) begin
            w_cand = (bus.i_rr ? {1'b0, r_ptr} : '0) + (SELW+1)'(off);
            if (w_cand >= (SELW+1)'(CHANNELS))
                w_cand = w_cand - (SELW+1)'(CHANNELS);
            if (!w_found && bus.i_valid[w_cand[SELW-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand[SELW-1:0];
            end
        end
    end

    assign w_gnt_any = w_space && !i_rst && w_found;
    assign w_inc     = {1'b0, w_gnt_idx} + (SELW+1)'(1);

    always_comb begin
        w_ready = '0;
        for (int k = 0; k < CHANNELS; k++)
            w_ready[k] = w_gnt_any && (w_gnt_idx == SELW'(k));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else if (w_gnt_any) begin
            r_valid <= 1'b1;
            r_data  <= bus.i_data[int'(w_gnt_idx)*WIDTH +: WIDTH];
            r_sel   <= w_gnt_idx;
            r_ptr   <= (w_inc == (SELW+1)'(CHANNELS)) ? '0 : w_inc[SELW-1:0];
        end else if (r_valid && bus.i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.o_ready = w_ready;
    assign bus.o_valid = r_valid;
    assign bus.o_data  = r_data;
    assign bus.o_sel   = r_sel;
endmodule

// File: tb/tb_rr_wordmux.sv
// Directed bench for rr_wordmux (4 x 16-bit): grants are checked in the
// stimulus loop, delivered words by a scoreboard monitor on the output side.
module tb_rr_wordmux;
    localparam int WIDTH = 16;
    localparam int CH    = 4;
    localparam int SELW  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_wordmux_if #(.WIDTH(WIDTH), .CHANNELS(CH), .SELW(SELW)) bus ();

    rr_wordmux #(.WIDTH(WIDTH), .CHANNELS(CH), .SELW(SELW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [15:0] data;
        int          sel;
    } exp_t;

    exp_t        q[$];
    int          nvec = 0;
    int          nerr = 0;
    bit          mon_en = 1'b0;
    logic [15:0] dat [CH];

    // Masks are written channel 3 .. channel 0, left to right.
    function automatic logic [0:CH-1] vm(input logic [3:0] m);
        logic [0:CH-1] v;
        for (int k = 0; k < CH; k++) v[k] = m[k];
        return v;
    endfunction

    function automatic logic [3:0] rm(input logic [0:CH-1] r);
        logic [3:0] m;
        for (int k = 0; k < CH; k++) m[k] = r[k];
        return m;
    endfunction

    always @(negedge clk) begin
        if (mon_en && bus.o_valid && bus.i_ready) begin
            exp_t e;
            nvec++;
            if (q.size() == 0) begin
                nerr++;
                $display("FAIL out_unexpected: got sel=%0d data=%h, none expected", bus.o_sel, bus.o_data);
            end else begin
                e = q.pop_front();
                if (bus.o_data != e.data || bus.o_sel != SELW'(e.sel)) begin
                    nerr++;
                    $display("FAIL out_word: got sel=%0d data=%h, want sel=%0d data=%h",
                             bus.o_sel, bus.o_data, e.sel, e.data);
                end
            end
        end
    end

    task automatic check_zero(input string nm);
        nvec++;
        if (bus.o_valid !== 1'b0 || bus.o_data !== 16'h0 || bus.o_sel !== 2'd0) begin
            nerr++;
            $display("FAIL %s: got v=%b d=%h s=%0d, want v=0 d=0000 s=0", nm, bus.o_valid, bus.o_data, bus.o_sel);
        end
    endtask

    // One cycle: drive, check o_ready mid-cycle, optionally expect a loaded word.
    task automatic step(input logic r, input logic [3:0] m, input logic rr, input logic rdy,
                        input logic [3:0] exp_rdy, input bit push, input int psel);
        exp_t e;
        rst         = r;
        bus.i_valid = vm(m);
        bus.i_rr    = rr;
        bus.i_ready = rdy;
        @(negedge clk);
        nvec++;
        if (rm(bus.o_ready) !== exp_rdy) begin
            nerr++;
            $display("FAIL o_ready: got %b, want %b (valid=%b rr=%b)", rm(bus.o_ready), exp_rdy, m, rr);
        end
        if (push) begin
            e.data = dat[psel];
            e.sel  = psel;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            check_zero("reset_state");
        end
    endtask

    initial begin
        dat[0] = 16'h0A00; dat[1] = 16'h0B11; dat[2] = 16'h0115; dat[3] = 16'h00EA;
        for (int k = 0; k < CH; k++) bus.i_data[k*WIDTH +: WIDTH] = dat[k];
        rst = 1'b1; bus.i_valid = '0; bus.i_rr = 1'b0; bus.i_ready = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        step(1, 4'b1111, 0, 1, 4'b0000, 0, 0);
        step(1, 4'b1111, 1, 1, 4'b0000, 0, 0);

        // single word from ch2
        step(0, 4'b0100, 0, 1, 4'b0100, 1, 2);
        step(0, 4'b0000, 0, 1, 4'b0000, 0, 0);

        // pointer now 3: wrap with ch0/ch1 only
        step(0, 4'b0011, 1, 1, 4'b0001, 1, 0);
        step(0, 4'b0011, 1, 1, 4'b0010, 1, 1);
        step(0, 4'b0011, 1, 1, 4'b0001, 1, 0);

        // ch3 grant brings pointer to 0, then full round-robin sweep
        step(0, 4'b1000, 1, 1, 4'b1000, 1, 3);
        for (int i = 0; i < 8; i++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (i % 4);
            step(0, 4'b1111, 1, 1, oh, 1, i % 4);
        end

        // fixed priority
        for (int i = 0; i < 4; i++) step(0, 4'b1011, 0, 1, 4'b0001, 1, 0);

        // backpressure on a held ch3 word
        step(0, 4'b1000, 0, 1, 4'b1000, 1, 3);
        for (int i = 0; i < 3; i++) begin
            step(0, 4'b1111, 0, 0, 4'b0000, 0, 0);
            nvec++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== 16'h00EA || bus.o_sel !== 2'd3) begin
                nerr++;
                $display("FAIL hold: got v=%b d=%h s=%0d, want v=1 d=00ea s=3", bus.o_valid, bus.o_data, bus.o_sel);
            end
        end
        step(0, 4'b1111, 0, 1, 4'b0001, 1, 0);

        // reset with ch3 word held, then arbitration restarts at ch0
        step(0, 4'b1000, 0, 1, 4'b1000, 1, 3);
        step(1, 4'b1111, 1, 0, 4'b0000, 0, 0);
        step(0, 4'b1111, 1, 1, 4'b0001, 1, 0);

        // reset with pointer at 2 must also restart at ch0
        step(0, 4'b0010, 0, 1, 4'b0010, 1, 1);
        step(1, 4'b1111, 1, 0, 4'b0000, 0, 0);
        step(0, 4'b1111, 1, 1, 4'b0001, 1, 0);

        // drain and idle
        step(0, 4'b0000, 1, 1, 4'b0000, 0, 0);
        step(0, 4'b0000, 1, 1, 4'b0000, 0, 0);
        nvec++;
        if (q.size() != 0 || bus.o_valid !== 1'b0) begin
            nerr++;
            $display("FAIL drain: got %0d pending, o_valid=%b, want 0 pending, o_valid=0", q.size(), bus.o_valid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish within 100000 time units");
        $fatal(1, "timeout");
    end
endmodule
